// File: rtl/card_shoe_dealer.sv
// card_shoe_dealer: finite multi-deck card shoe dealing 4-bit card codes on request
// Ports: slow_clock clock, resetb async active-low reset; deal_req asks for a card,
// shuffle refills the shoe; busy is high while searching for a non-exhausted rank;
// card_valid pulses for one cycle with the dealt code on new_card (held until the next deal);
// cards_left is the total remaining and shoe_empty flags cards_left == 0.
module card_shoe_dealer #(
  parameter int NUM_DECKS = 1
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       deal_req,
  input  logic       shuffle,
  output logic       busy,
  output logic       card_valid,
  output logic [3:0] new_card,
  output logic [8:0] cards_left,
  output logic       shoe_empty
);
  localparam logic [5:0] FULL = 6'(4 * NUM_DECKS);
  localparam logic [8:0] TOTAL = 9'(52 * NUM_DECKS);
  typedef enum logic {IDLE, SEARCH} state_t;
  state_t     state;
  logic [3:0] rr;
  logic [3:0] cand;
  logic [5:0] rem [1:13];
  assign busy = state == SEARCH;
  assign shoe_empty = cards_left == 9'd0;
  // rr free-runs in every state so the rank picked depends on request timing
  always_ff @(posedge slow_clock or negedge resetb)
    if (!resetb) begin
      rr <= 4'd1;
      cand <= 4'd1;
      state <= IDLE;
      new_card <= 4'd0;
      card_valid <= 1'b0;
      cards_left <= TOTAL;
      for (int r = 1; r <= 13; r++) rem[r] <= FULL;
    end else begin
      rr <= rr == 4'd13 ? 4'd1 : rr + 4'd1;
      card_valid <= 1'b0;
      if (shuffle) begin
        state <= IDLE;
        cards_left <= TOTAL;
        for (int r = 1; r <= 13; r++) rem[r] <= FULL;
      end else if (state == IDLE) begin
        if (deal_req && !shoe_empty) begin
          cand <= rr;
          state <= SEARCH;
        end
      end else if (rem[cand] != 6'd0) begin
        rem[cand] <= rem[cand] - 6'd1;
        cards_left <= cards_left - 9'd1;
        new_card <= cand;
        card_valid <= 1'b1;
        state <= IDLE;
      end else begin
        // exhausted rank: try the next one; the shoe was non-empty on entry so this ends
        cand <= cand == 4'd13 ? 4'd1 : cand + 4'd1;
      end
    end
endmodule

// File: tb/tb_card_shoe_dealer.sv
// tb_card_shoe_dealer: directed bench with a shoe-level reference model for card_shoe_dealer
module tb_card_shoe_dealer;
  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       deal_req = 1'b0;
  logic       shuffle = 1'b0;
  logic       busy, card_valid, shoe_empty;
  logic [3:0] new_card;
  logic [8:0] cards_left;
  logic       resetb2 = 1'b0;
  logic       deal2 = 1'b0;
  logic       shuffle2 = 1'b0;
  logic       busy2, valid2, empty2;
  logic [3:0] card2;
  logic [8:0] left2;
  int total = 0;
  int bad = 0;
  int m_e, m_left, m_new, m_card, m_deal_e;
  bit m_search, m_valid;
  int m_rem [1:13];
  int tally [0:15];
  int prev;
  bit got;

  card_shoe_dealer #(.NUM_DECKS(1)) dut (
    .slow_clock(clk), .resetb(resetb), .deal_req(deal_req), .shuffle(shuffle),
    .busy(busy), .card_valid(card_valid), .new_card(new_card),
    .cards_left(cards_left), .shoe_empty(shoe_empty)
  );

  card_shoe_dealer #(.NUM_DECKS(2)) dut2 (
    .slow_clock(clk), .resetb(resetb2), .deal_req(deal2), .shuffle(shuffle2),
    .busy(busy2), .card_valid(valid2), .new_card(card2),
    .cards_left(left2), .shoe_empty(empty2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_e = 0;
    m_left = 52;
    m_new = 0;
    m_search = 0;
    m_valid = 0;
    for (int r = 1; r <= 13; r++) m_rem[r] = 4;
  endtask

  // Shoe-level model: on acceptance, the dealt rank is the first rank with cards left,
  // scanning cyclically from the free-running rank, and it appears one edge per skipped rank later.
  task automatic model_edge();
    int c, k;
    m_valid = 0;
    if (shuffle) begin
      for (int r = 1; r <= 13; r++) m_rem[r] = 4;
      m_left = 52;
      m_search = 0;
    end else if (m_search) begin
      if (m_e == m_deal_e) begin
        m_rem[m_card]--;
        m_left--;
        m_new = m_card;
        m_valid = 1;
        m_search = 0;
      end
    end else if (deal_req && m_left != 0) begin
      c = m_e % 13 + 1;
      k = 0;
      while (m_rem[c] == 0) begin
        c = c % 13 + 1;
        k++;
      end
      m_card = c;
      m_deal_e = m_e + 1 + k;
      m_search = 1;
    end
    m_e++;
  endtask

  task automatic compare_all();
    check("busy", busy, m_search);
    check("card_valid", card_valid, m_valid);
    check("new_card", new_card, m_new);
    check("cards_left", cards_left, m_left);
    check("shoe_empty", shoe_empty, m_left == 0);
    if (card_valid) tally[new_card]++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic request_at(input int edge_idx);
    while (m_e < edge_idx) step();
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
  endtask

  task automatic deal_one();
    repeat ($urandom_range(0, 3)) step();
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    got = 0;
    for (int i = 0; i < 15 && !got; i++) begin
      step();
      got = card_valid;
    end
    if (!got) check("deal_timeout", card_valid, 1);
  endtask

  initial begin
    for (int r = 0; r < 16; r++) tally[r] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_new_card", new_card, 0);
    check("rst_valid", card_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_left", cards_left, 52);
    check("rst_empty", shoe_empty, 0);
    @(negedge clk);
    resetb = 1'b1;
    model_reset();
    // first deal: rank counter is 1 on the first edge
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    check("first_busy", busy, 1);
    step();
    check("first_valid", card_valid, 1);
    check("first_card", new_card, 1);
    check("first_left", cards_left, 51);
    // three more Aces, then a fifth request landing on rank 1 skips to rank 2
    request_at(13);
    request_at(26);
    request_at(39);
    request_at(52);
    step();
    check("skip_wait_valid", card_valid, 0);
    check("skip_wait_busy", busy, 1);
    step();
    check("skip_valid", card_valid, 1);
    check("skip_card", new_card, 2);
    check("skip_left", cards_left, 47);
    check("skip_aces", tally[1], 4);
    for (int i = 0; i < 17; i++) deal_one();
    check("pre_shuffle_left", cards_left, 30);
    // shuffle and deal on the same edge
    prev = m_new;
    shuffle = 1'b1;
    deal_req = 1'b1;
    step();
    shuffle = 1'b0;
    deal_req = 1'b0;
    check("shuf_valid", card_valid, 0);
    check("shuf_busy", busy, 0);
    check("shuf_left", cards_left, 52);
    check("shuf_card", new_card, prev);
    step();
    check("shuf_valid2", card_valid, 0);
    // shuffle during a search
    deal_one();
    deal_one();
    check("pre_abort_left", cards_left, 50);
    prev = m_new;
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    check("abort_busy_pre", busy, 1);
    shuffle = 1'b1;
    step();
    shuffle = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", card_valid, 0);
    check("abort_left", cards_left, 52);
    check("abort_card", new_card, prev);
    step();
    check("abort_valid2", card_valid, 0);
    // drain a full shoe
    for (int r = 0; r < 16; r++) tally[r] = 0;
    for (int i = 0; i < 52; i++) deal_one();
    for (int r = 1; r <= 13; r++) check($sformatf("drain_rank%0d", r), tally[r], 4);
    check("drain_rank0", tally[0], 0);
    check("drain_left", cards_left, 0);
    check("drain_empty", shoe_empty, 1);
    deal_req = 1'b1;
    repeat (3) begin
      step();
      check("empty_valid", card_valid, 0);
      check("empty_busy", busy, 0);
    end
    deal_req = 1'b0;
    // two-deck instance: reset while searching
    @(negedge clk);
    resetb2 = 1'b1;
    deal2 = 1'b1;
    step();
    deal2 = 1'b0;
    check("d2_busy", busy2, 1);
    step();
    check("d2_valid", valid2, 1);
    check("d2_card", card2, 1);
    check("d2_left", left2, 103);
    deal2 = 1'b1;
    step();
    deal2 = 1'b0;
    check("d2_busy2", busy2, 1);
    #2;
    resetb2 = 1'b0;
    #1;
    check("d2_rst_busy", busy2, 0);
    check("d2_rst_valid", valid2, 0);
    check("d2_rst_card", card2, 0);
    check("d2_rst_left", left2, 104);
    check("d2_rst_empty", empty2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/card_shoe_dealer.md
Name: card_shoe_dealer

Overview:
- Source end of the card-code interface: produces 4-bit card codes (0 = no card, 1 = Ace, 2–10 = pips, 11 = J, 12 = Q, 13 = K) for the 7-segment card decoders and the scoring logic.
- Models a finite shoe of NUM_DECKS standard decks and deals one card per request via a request/valid handshake.
- Pseudo-randomness comes from a free-running rank counter sampled at request time. Exhausted ranks are skipped by a multi-cycle search.

Parameters:
- NUM_DECKS, default 1: number of 52-card decks in the shoe. Legal range is 1..8.

Ports:
- slow_clock  in  1: the single clock; all state updates on its rising edge.
- resetb  in  1: asynchronous, active-low reset.
- deal_req  in  1: request one card. Sampled on rising edges.
- shuffle  in  1: refill the shoe to full.
- busy  out  1: high while a request is in progress.
- card_valid  out  1: one-cycle pulse when a new card is dealt.
- new_card  out  4: last dealt card code. Held until the next deal.
- cards_left  out  9: cards remaining in the shoe.
- shoe_empty  out  1: high when cards_left == 0.

Behaviour:
- Reset (resetb low, asynchronous, at any time including mid-search):
  - rank counter rr = 1, state = IDLE.
  - new_card = 0, card_valid = 0, busy = 0.
  - rem[r] = 4*NUM_DECKS for every rank r in 1..13.
  - cards_left = 52*NUM_DECKS, shoe_empty = 0.
- rr: increments on every edge and wraps 13 -> 1. It counts in every state and is never held.
- rem[r]: 6-bit per-rank remaining counts. cards_left: 9-bit total. cards_left always equals the sum of rem.
- States:
  - IDLE:
    - shuffle = 1: restore all rem and cards_left. Stay in IDLE.
    - Else if deal_req = 1 and shoe_empty = 0: cand <= rr (value before this edge's increment). Go to SEARCH.
    - deal_req while shoe_empty = 1: ignored; no card_valid.
  - SEARCH:
    - shuffle = 1: abort. Restore counts, return to IDLE, no card_valid, new_card unchanged.
    - Else if rem[cand] != 0:
      - rem[cand] -= 1, cards_left -= 1.
      - new_card <= cand, card_valid <= 1 for exactly one cycle.
      - Return to IDLE.
    - Else: cand <= (cand == 13) ? 1 : cand + 1. Stay in SEARCH.
    - Termination is guaranteed because the shoe was non-empty on entry.
- Latency:
  - deal_req sampled at edge t: card_valid is high from edge t+1+k to edge t+2+k, where k (0..12) is the number of exhausted ranks skipped.
  - Maximum latency is 14 edges.
- busy is combinational: busy = (state == SEARCH).
  - deal_req while busy is ignored and is not queued.
  - deal_req may be a level: a held deal_req redeals on the first IDLE edge after the previous deal.
- shuffle has priority over deal_req on the same edge. The request is dropped and new_card is unchanged.
- card_valid is never high while shoe_empty was high at the request edge.
- No counter underflows or overflows under any input sequence.
- new_card only ever takes the values 0..13.

Test Plan:
- Reset check: after reset, new_card = 0, card_valid = 0, busy = 0, cards_left = 52, shoe_empty = 0.
- First deal:
  - Stimulus: release reset, then hold deal_req = 1 on the first edge only.
  - Required: busy high for 1 cycle, then card_valid pulses with new_card = 1 (Ace) and cards_left = 51.
- Skip search:
  - Stimulus: time four requests (every 13 edges, bench-modelled rr) so cand = 1 each time, producing four Aces.
  - Required: a fifth request with cand = 1 yields new_card = 2 one edge later than normal. rem[1] = 0, cards_left = 47.
- Drain the shoe:
  - Stimulus: deal 52 cards with random request timing.
  - Required: each rank is dealt exactly 4 times, then shoe_empty = 1 and cards_left = 0. A further deal_req gives no card_valid and busy stays 0.
- Shuffle priority:
  - Stimulus: shuffle and deal_req asserted on the same edge with cards_left = 30.
  - Required: no card_valid, cards_left = 52, new_card unchanged. The same holds for shuffle asserted during SEARCH.
- Reset mid-search:
  - Stimulus: drive resetb low while busy = 1 in a NUM_DECKS = 2 build.
  - Required: immediately (before the next edge) busy = 0, card_valid = 0, new_card = 0, cards_left = 104.
